// File: rtl/multi_reaction_timer.sv
// Multi-player reaction timer: LFSR go-delay, BCD millisecond counter, winner/foul detection.
// Optional best-time tracking is enabled by defining MULTI_REACTION_BEST_TIME_EN.
module multi_reaction_timer #(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_DIGITS   = 4,
    parameter int TICKS_PER_MS = 100000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    localparam int WIN_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      RESET_N,
    input  logic                      start,
    input  logic [NUM_PLAYERS-1:0]    enter,
    output logic                      led_r,
    output logic                      led_g,
    output logic                      led_b,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [WIN_W-1:0]          winner,
    output logic                      timeout,
    output logic                      foul,
`ifdef MULTI_REACTION_BEST_TIME_EN
    output logic [4*NUM_DIGITS-1:0]   best_digits,
    output logic                      new_best,
`endif
    output logic                      rs_en
);

    localparam int DW = $clog2(MIN_DELAY_MS + (2 ** RAND_BITS)) + 1;
    localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_GO, S_DONE, S_FOUL} state_t;

    // LED pattern {r,g,b} shown while in a given state
    function automatic logic [2:0] led_code(input state_t s);
        case (s)
            S_IDLE:  led_code = 3'b001;
            S_WAIT:  led_code = 3'b100;
            S_GO:    led_code = 3'b010;
            S_DONE:  led_code = 3'b011;
            S_FOUL:  led_code = 3'b101;
            default: led_code = 3'b001;
        endcase
    endfunction

    function automatic logic [WIN_W-1:0] lowest_idx(input logic [NUM_PLAYERS-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = WIN_W'(i);
        end
    endfunction

    function automatic logic [4*NUM_DIGITS-1:0] bcd_inc(input logic [4*NUM_DIGITS-1:0] d);
        logic carry;
        bcd_inc = d;
        carry   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (d[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = d[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic all_nines(input logic [4*NUM_DIGITS-1:0] d);
        all_nines = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (d[4*i +: 4] != 4'd9) all_nines = 1'b0;
        end
    endfunction

    state_t                   r_state;
    logic                     r_start_q, r_start_edge;
    logic [NUM_PLAYERS-1:0]   r_enter_q, r_enter_edge;
    logic [15:0]              r_lfsr;
    logic [TW-1:0]            r_tick;
    logic [DW-1:0]            r_delay;
    logic [4*NUM_DIGITS-1:0]  r_digits;
    logic [WIN_W-1:0]         r_winner;
    logic                     r_timeout, r_foul, r_rs_en;
    logic                     r_led_r, r_led_g, r_led_b;
`ifdef MULTI_REACTION_BEST_TIME_EN
    logic [4*NUM_DIGITS-1:0]  r_best;
    logic                     r_new_best;
`endif

    logic w_strobe, w_any_enter, w_fb;
    assign w_strobe    = (r_tick == TW'(TICKS_PER_MS - 1));
    assign w_any_enter = |r_enter_edge;
    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Button edge detection and free-running LFSR
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_start_q    <= 1'b0;
            r_start_edge <= 1'b0;
            r_enter_q    <= '0;
            r_enter_edge <= '0;
            r_lfsr       <= 16'hACE1;
        end else begin
            r_start_q    <= start;
            r_start_edge <= start & ~r_start_q;
            r_enter_q    <= enter;
            r_enter_edge <= enter & ~r_enter_q;
            r_lfsr       <= {r_lfsr[14:0], w_fb};
        end
    end

    // Game FSM with registered outputs; the tick counter restarts on every state change
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_delay   <= '0;
            r_digits  <= '0;
            r_winner  <= '0;
            r_timeout <= 1'b0;
            r_foul    <= 1'b0;
            r_rs_en   <= 1'b0;
            {r_led_r, r_led_g, r_led_b} <= 3'b001;
`ifdef MULTI_REACTION_BEST_TIME_EN
            r_best     <= {NUM_DIGITS{4'd9}};
            r_new_best <= 1'b0;
`endif
        end else begin
`ifdef MULTI_REACTION_BEST_TIME_EN
            r_new_best <= 1'b0;
`endif
            r_tick <= w_strobe ? '0 : r_tick + TW'(1'b1);
            case (r_state)
                S_IDLE, S_DONE, S_FOUL: begin
                    if (r_start_edge) begin
                        r_state   <= S_WAIT;
                        r_tick    <= '0;
                        r_delay   <= DW'(MIN_DELAY_MS) + DW'(r_lfsr[RAND_BITS-1:0]);
                        r_digits  <= '0;
                        r_winner  <= '0;
                        r_timeout <= 1'b0;
                        r_foul    <= 1'b0;
                        r_rs_en   <= 1'b0;
                        {r_led_r, r_led_g, r_led_b} <= led_code(S_WAIT);
                    end
                end
                S_WAIT: begin
                    if (w_any_enter) begin
                        r_state  <= S_FOUL;
                        r_tick   <= '0;
                        r_winner <= lowest_idx(r_enter_edge);
                        r_foul   <= 1'b1;
                        {r_led_r, r_led_g, r_led_b} <= led_code(S_FOUL);
                    end else if (w_strobe) begin
                        if (r_delay <= DW'(1'b1)) begin
                            r_state <= S_GO;
                            r_tick  <= '0;
                            {r_led_r, r_led_g, r_led_b} <= led_code(S_GO);
                        end else begin
                            r_delay <= r_delay - DW'(1'b1);
                        end
                    end
                end
                S_GO: begin
                    // A press on a strobe cycle wins over the increment
                    if (w_any_enter) begin
                        r_state  <= S_DONE;
                        r_tick   <= '0;
                        r_winner <= lowest_idx(r_enter_edge);
                        r_rs_en  <= 1'b1;
                        {r_led_r, r_led_g, r_led_b} <= led_code(S_DONE);
`ifdef MULTI_REACTION_BEST_TIME_EN
                        if (r_digits < r_best) begin
                            r_best     <= r_digits;
                            r_new_best <= 1'b1;
                        end
`endif
                    end else if (w_strobe) begin
                        if (all_nines(r_digits)) begin
                            r_state   <= S_DONE;
                            r_tick    <= '0;
                            r_timeout <= 1'b1;
                            r_rs_en   <= 1'b1;
                            {r_led_r, r_led_g, r_led_b} <= led_code(S_DONE);
                        end else begin
                            r_digits <= bcd_inc(r_digits);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tick  <= '0;
                    {r_led_r, r_led_g, r_led_b} <= led_code(S_IDLE);
                end
            endcase
        end
    end

    assign led_r   = r_led_r;
    assign led_g   = r_led_g;
    assign led_b   = r_led_b;
    assign digits  = r_digits;
    assign winner  = r_winner;
    assign timeout = r_timeout;
    assign foul    = r_foul;
    assign rs_en   = r_rs_en;
`ifdef MULTI_REACTION_BEST_TIME_EN
    assign best_digits = r_best;
    assign new_best    = r_new_best;
`endif

endmodule

// File: tb/tb_multi_reaction_timer.sv
// Scoreboard bench for multi_reaction_timer: a 4-digit game instance and a 1-digit saturation instance.
module tb_multi_reaction_timer;

    typedef struct packed {
        logic [15:0] dig;
        logic        win;
        logic        tmo;
        logic        fl;
        logic [2:0]  rgb;
        logic [15:0] best;
        logic        nb;
    } exp_t;

    logic clk = 1'b0;
    logic RESET_N = 1'b0;
    logic start = 1'b0, start2 = 1'b0;
    logic [1:0] enter = 2'b00, enter2 = 2'b00;

    logic led_r, led_g, led_b, timeout, foul, rs_en, winner;
    logic [15:0] digits;
    logic led_r2, led_g2, led_b2, timeout2, foul2, rs_en2, winner2;
    logic [3:0] digits2;
    logic [15:0] best_digits;
    logic [3:0]  best_digits2;
    logic new_best, new_best2;

    int n_checks = 0;
    int n_errors = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic prev1 = 1'b0, prev2 = 1'b0;

    always #5 clk = ~clk;

    multi_reaction_timer #(.NUM_PLAYERS(2), .NUM_DIGITS(4), .TICKS_PER_MS(2),
                           .MIN_DELAY_MS(3), .RAND_BITS(2)) dut (
        .clk(clk), .RESET_N(RESET_N), .start(start), .enter(enter),
        .led_r(led_r), .led_g(led_g), .led_b(led_b), .digits(digits),
        .winner(winner), .timeout(timeout), .foul(foul),
`ifdef MULTI_REACTION_BEST_TIME_EN
        .best_digits(best_digits), .new_best(new_best),
`endif
        .rs_en(rs_en));

    multi_reaction_timer #(.NUM_PLAYERS(2), .NUM_DIGITS(1), .TICKS_PER_MS(2),
                           .MIN_DELAY_MS(3), .RAND_BITS(2)) dut2 (
        .clk(clk), .RESET_N(RESET_N), .start(start2), .enter(enter2),
        .led_r(led_r2), .led_g(led_g2), .led_b(led_b2), .digits(digits2),
        .winner(winner2), .timeout(timeout2), .foul(foul2),
`ifdef MULTI_REACTION_BEST_TIME_EN
        .best_digits(best_digits2), .new_best(new_best2),
`endif
        .rs_en(rs_en2));

`ifndef MULTI_REACTION_BEST_TIME_EN
    assign best_digits  = 16'h9999;
    assign best_digits2 = 4'h9;
    assign new_best     = 1'b0;
    assign new_best2    = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor for the 4-digit instance: compare on every new result/foul presentation
    always @(negedge clk) begin
        if ((rs_en | foul) && !prev1) begin
            if (q1.size() == 0) begin
                check("unexpected_result", {16'h0, digits}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("digits", {16'h0, digits}, {16'h0, e.dig});
                check("winner", {31'h0, winner}, {31'h0, e.win});
                check("timeout", {31'h0, timeout}, {31'h0, e.tmo});
                check("foul", {31'h0, foul}, {31'h0, e.fl});
                check("rs_en", {31'h0, rs_en}, {31'h0, ~e.fl});
                check("leds_rgb", {29'h0, led_r, led_g, led_b}, {29'h0, e.rgb});
`ifdef MULTI_REACTION_BEST_TIME_EN
                check("best_digits", {16'h0, best_digits}, {16'h0, e.best});
                check("new_best", {31'h0, new_best}, {31'h0, e.nb});
`endif
            end
        end
        prev1 <= rs_en | foul;
    end

    // Monitor for the 1-digit saturation instance
    always @(negedge clk) begin
        if ((rs_en2 | foul2) && !prev2) begin
            if (q2.size() == 0) begin
                check("unexpected_result2", {28'h0, digits2}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("sat_digits", {28'h0, digits2}, {16'h0, e.dig});
                check("sat_timeout", {31'h0, timeout2}, {31'h0, e.tmo});
                check("sat_winner", {31'h0, winner2}, {31'h0, e.win});
                check("sat_leds", {29'h0, led_r2, led_g2, led_b2}, {29'h0, e.rgb});
`ifdef MULTI_REACTION_BEST_TIME_EN
                check("sat_best", {28'h0, best_digits2}, {16'h0, e.best});
                check("sat_new_best", {31'h0, new_best2}, {31'h0, e.nb});
`endif
            end
        end
        prev2 <= rs_en2 | foul2;
    end

    task automatic start_pulse(input logic sel);
        @(negedge clk);
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Wait until green LED; count WAIT cycles (red) on the way
    task automatic wait_go(input logic sel, output int nw);
        logic ok;
        ok = 1'b0;
        nw = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sel ? led_g2 : led_g) begin
                ok = 1'b1;
                break;
            end
            if (sel ? led_r2 : led_r) nw++;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_go_timeout actual=no_green required=green");
        end
    endtask

    // One game on the 4-digit instance: press after n posedges in GO
    task automatic play(input logic [1:0] who, input int n, input exp_t e, output int nw);
        start_pulse(1'b0);
        wait_go(1'b0, nw);
        q1.push_back(e);
        repeat (n) @(posedge clk);
        @(negedge clk);
        enter = who;
        repeat (4) @(negedge clk);
        enter = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int nw;
        int cnt;
        exp_t e;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_led_b", {31'h0, led_b}, 32'h1);
        check("rst_led_r", {31'h0, led_r}, 32'h0);
        check("rst_led_g", {31'h0, led_g}, 32'h0);
        check("rst_digits", {16'h0, digits}, 32'h0);
        check("rst_rs_en", {31'h0, rs_en}, 32'h0);
        check("rst_foul", {31'h0, foul}, 32'h0);
        check("rst_best", {16'h0, best_digits}, 32'h9999);
        RESET_N = 1'b1;

        // Enter in IDLE is ignored
        enter = 2'b11;
        repeat (3) @(negedge clk);
        enter = 2'b00;
        repeat (3) @(negedge clk);
        check("idle_led_b", {31'h0, led_b}, 32'h1);
        check("idle_led_r", {31'h0, led_r}, 32'h0);
        check("idle_rs_en", {31'h0, rs_en}, 32'h0);

        // Normal game: 5 ms, player 1, press coincides with a strobe
        e = '{dig: 16'h0005, win: 1'b1, tmo: 1'b0, fl: 1'b0, rgb: 3'b011, best: 16'h0005, nb: 1'b1};
        play(2'b10, 10, e, nw);
        check("wait_ms_even", nw % 2, 32'h0);
        check("wait_ms_range", {31'h0, (nw >= 6 && nw <= 12)}, 32'h1);

        // False start by player 0
        start_pulse(1'b0);
        q1.push_back('{dig: 16'h0000, win: 1'b0, tmo: 1'b0, fl: 1'b1, rgb: 3'b101,
                       best: 16'h0005, nb: 1'b0});
        @(negedge clk);
        check("wait_led_r", {31'h0, led_r}, 32'h1);
        enter = 2'b01;
        repeat (4) @(negedge clk);
        enter = 2'b00;
        repeat (2) @(negedge clk);

        // Restart from FOUL goes to WAIT
        start_pulse(1'b0);
        @(negedge clk);
        check("foul_restart_led_r", {31'h0, led_r}, 32'h1);
        check("foul_restart_led_b", {31'h0, led_b}, 32'h0);
        check("foul_restart_foul", {31'h0, foul}, 32'h0);

        // Simultaneous press off-strobe: one more increment lands before the edge registers
        wait_go(1'b0, nw);
        q1.push_back('{dig: 16'h0004, win: 1'b0, tmo: 1'b0, fl: 1'b0, rgb: 3'b011,
                       best: 16'h0004, nb: 1'b1});
        repeat (7) @(posedge clk);
        @(negedge clk);
        enter = 2'b11;
        repeat (4) @(negedge clk);
        enter = 2'b00;
        repeat (2) @(negedge clk);

        // Saturation on the 1-digit instance
        start_pulse(1'b1);
        wait_go(1'b1, nw);
        q2.push_back('{dig: 16'h0009, win: 1'b0, tmo: 1'b1, fl: 1'b0, rgb: 3'b011,
                       best: 16'h0009, nb: 1'b0});
        cnt = 0;
        while (!rs_en2 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("sat_go_cycles", cnt, 32'd20);
        repeat (2) @(negedge clk);

        // Mid-game reset
        start_pulse(1'b0);
        wait_go(1'b0, nw);
        repeat (3) @(negedge clk);
        RESET_N = 1'b0;
        #1;
        check("midrst_led_b", {31'h0, led_b}, 32'h1);
        check("midrst_led_g", {31'h0, led_g}, 32'h0);
        check("midrst_digits", {16'h0, digits}, 32'h0);
        check("midrst_rs_en", {31'h0, rs_en}, 32'h0);
        check("midrst_best", {16'h0, best_digits}, 32'h9999);
        @(negedge clk);
        RESET_N = 1'b1;
        repeat (2) @(negedge clk);

        // Best-time sequence: 7 ms, 4 ms, 6 ms
        play(2'b01, 14, '{dig: 16'h0007, win: 1'b0, tmo: 1'b0, fl: 1'b0, rgb: 3'b011,
                          best: 16'h0007, nb: 1'b1}, nw);
        play(2'b10, 8,  '{dig: 16'h0004, win: 1'b1, tmo: 1'b0, fl: 1'b0, rgb: 3'b011,
                          best: 16'h0004, nb: 1'b1}, nw);
        play(2'b01, 12, '{dig: 16'h0006, win: 1'b0, tmo: 1'b0, fl: 1'b0, rgb: 3'b011,
                          best: 16'h0004, nb: 1'b0}, nw);

        repeat (4) @(negedge clk);
        check("q1_drained", q1.size(), 32'h0);
        check("q2_drained", q2.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
